// File: rtl/mux_unit_arb.sv
// Per-output arbiter/mux: picks one requesting input, locks it for a whole packet,
// and forwards its beats through a 2-entry skid buffer with registered outputs.
module mux_unit_arb #(
  parameter int unsigned S_DATA_COUNT = 10,
  parameter int unsigned M_DATA_COUNT = 10,
  parameter int unsigned T_DATA_WIDTH = 64,
  parameter int unsigned NUM_CHANNEL  = 0,
  parameter int unsigned ARB_MODE     = 0,
  parameter int unsigned T_ID_WIDTH   = $clog2(S_DATA_COUNT),
  parameter int unsigned T_DEST_WIDTH = $clog2(M_DATA_COUNT)
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [S_DATA_COUNT*T_DATA_WIDTH-1:0]   s_data_i,
  input  logic [S_DATA_COUNT*T_DEST_WIDTH-1:0]   s_dest_i,
  input  logic [S_DATA_COUNT-1:0]                s_last_i,
  input  logic [S_DATA_COUNT-1:0]                s_valid_i,
  output logic [S_DATA_COUNT-1:0]                s_ready_o,
  output logic [T_ID_WIDTH-1:0]                  m_id_o,
  output logic [T_DATA_WIDTH-1:0]                m_data_o,
  output logic                                   m_last_o,
  output logic                                   m_valid_o,
  input  logic                                   m_ready_i,
  output logic [31:0]                            pkt_cnt_o
);

  typedef enum logic {StIdle, StBusy} state_e;

  state_e                  state_q, state_d;
  logic [T_ID_WIDTH-1:0]   grant_q, grant_d;
  logic [T_ID_WIDTH-1:0]   rr_q, rr_d;
  logic [T_ID_WIDTH-1:0]   grant_fp, grant_rr;
  logic [S_DATA_COUNT-1:0] req;
  logic                    rr_found;
  int unsigned             rr_idx;
  logic                    accept;
  logic                    pop;
  logic [T_DATA_WIDTH-1:0] in_data;
  logic                    in_last;

  logic                    m_valid_q, m_last_q, skid_full_q, skid_last_q;
  logic [T_DATA_WIDTH-1:0] m_data_q, skid_data_q;
  logic [T_ID_WIDTH-1:0]   m_id_q, skid_id_q;
  logic [31:0]             pkt_cnt_q;

  always_comb begin
    req = '0;
    for (int i = 0; i < int'(S_DATA_COUNT); i++) begin
      req[i] = s_valid_i[i] &&
               (s_dest_i[i*T_DEST_WIDTH +: T_DEST_WIDTH] == T_DEST_WIDTH'(NUM_CHANNEL));
    end
  end

  // Fixed priority: descending scan so the lowest set index is the last to write.
  always_comb begin
    grant_fp = '0;
    for (int i = int'(S_DATA_COUNT) - 1; i >= 0; i--) begin
      if (req[i]) grant_fp = T_ID_WIDTH'(i);
    end
  end

  always_comb begin
    grant_rr = '0;
    rr_found = 1'b0;
    rr_idx   = 0;
    for (int unsigned k = 0; k < S_DATA_COUNT; k++) begin
      rr_idx = (32'(rr_q) + k) % S_DATA_COUNT;
      if (!rr_found && req[rr_idx]) begin
        grant_rr = T_ID_WIDTH'(rr_idx);
        rr_found = 1'b1;
      end
    end
  end

  assign in_data = s_data_i[grant_q*T_DATA_WIDTH +: T_DATA_WIDTH];
  assign in_last = s_last_i[grant_q];
  assign pop     = m_valid_q && m_ready_i;

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_d      = rr_q;
    s_ready_o = '0;
    accept    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (|req) begin
          grant_d = (ARB_MODE == 1) ? grant_fp : grant_rr;
          state_d = StBusy;
        end
      end
      StBusy: begin
        s_ready_o[grant_q] = !skid_full_q;
        accept             = s_valid_i[grant_q] && !skid_full_q;
        if (accept && in_last) begin
          state_d = StIdle;
          rr_d    = (grant_q == T_ID_WIDTH'(S_DATA_COUNT - 1)) ? '0 : grant_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      grant_q <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
    end
  end

  // Output stage plus one spill slot; input ready drops only while the spill slot is full.
  always_ff @(posedge clk) begin
    if (reset) begin
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      m_last_q    <= 1'b0;
      m_id_q      <= '0;
      skid_full_q <= 1'b0;
      skid_data_q <= '0;
      skid_last_q <= 1'b0;
      skid_id_q   <= '0;
      pkt_cnt_q   <= '0;
    end else begin
      if (pop && m_last_q) pkt_cnt_q <= pkt_cnt_q + 32'd1;
      if (skid_full_q) begin
        if (pop) begin
          m_valid_q   <= 1'b1;
          m_data_q    <= skid_data_q;
          m_last_q    <= skid_last_q;
          m_id_q      <= skid_id_q;
          skid_full_q <= 1'b0;
        end
      end else if (accept) begin
        if (!m_valid_q || pop) begin
          m_valid_q <= 1'b1;
          m_data_q  <= in_data;
          m_last_q  <= in_last;
          m_id_q    <= grant_q;
        end else begin
          skid_full_q <= 1'b1;
          skid_data_q <= in_data;
          skid_last_q <= in_last;
          skid_id_q   <= grant_q;
        end
      end else if (pop) begin
        m_valid_q <= 1'b0;
      end
    end
  end

  assign m_valid_o = m_valid_q;
  assign m_data_o  = m_data_q;
  assign m_last_o  = m_last_q;
  assign m_id_o    = m_id_q;
  assign pkt_cnt_o = pkt_cnt_q;

endmodule
